// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and helpers for the hazard scoreboard: the
//                tracker entry layout, the register-index width and a
//                saturating-increment helper for the performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Architectural register count the entry layout is built for; the top
  // level checks its NUM_REGS parameter against this at elaboration.
  localparam int PKG_NUM_REGS = 8;
  localparam int REG_W        = $clog2(PKG_NUM_REGS);

  // Widest counter the saturating helper can serve.
  localparam int SAT_MAX_W = 32;

  // One in-flight instruction downstream of decode.
  typedef struct packed {
    logic             v;   // slot holds a real register-writing instruction
    logic [REG_W-1:0] rd;  // destination register
    logic             ld;  // producer is a memory load
  } sb_entry_t;

  // Increment the low 'width' bits of cnt, holding at all-ones instead of
  // wrapping. Bits above 'width' are returned as zero.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(
    input logic [SAT_MAX_W-1:0] cnt,
    input int unsigned          width
  );
    logic [SAT_MAX_W-1:0] mask;
    mask = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - width);
    if ((cnt & mask) == mask) begin
      sat_inc = cnt & mask;
    end else begin
      sat_inc = (cnt + 1'b1) & mask;
    end
  endfunction

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_scoreboard_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Event counter that adds one on every enabled cycle and
//                sticks at all-ones rather than wrapping back to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // The helper works on a fixed wide vector; only the low CNT_W bits matter.
  if (CNT_W < 1 || CNT_W > SAT_MAX_W) begin : g_bad_cnt_w
    $error("sat_counter: CNT_W must be in 1..%0d", SAT_MAX_W);
  end

  // Next count: saturating increment when enabled, hold otherwise.
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = CNT_W'(sat_inc(SAT_MAX_W'(count_q), CNT_W));
    end
  end

  // Count register, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Pipeline hazard unit. Keeps the destination registers of the
//                instructions downstream of decode in a shift-register
//                tracker, compares the decoding instruction's sources against
//                it and raises stall / flush controls for the IF_ID and ID_EX
//                pipeline registers. Stall and flush cycles are counted in
//                saturating performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS  = 8,
  parameter int STAGES    = 3,
  parameter int BR_STAGE  = 1,
  parameter int FWD_EN    = 0,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_rs_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rt_valid,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rd_valid,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_is_load,
  input  logic             br_taken,
  output logic             stall,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Number of tracker slots that take part in matching. With a write-before-
  // read register file the oldest slot's value is already visible to decode.
  localparam int WIN_LEN = (WB_BYPASS != 0) ? (STAGES - 1) : STAGES;

  // --------------------------------------------------------------------------
  // Configuration sanity
  // --------------------------------------------------------------------------
  if ($clog2(NUM_REGS) != REG_W) begin : g_bad_num_regs
    $error("hazard_scoreboard: NUM_REGS=%0d does not match the entry layout (REG_W=%0d)",
           NUM_REGS, REG_W);
  end

  if (STAGES < 1) begin : g_bad_stages
    $error("hazard_scoreboard: STAGES must be at least 1");
  end

  if (BR_STAGE < 0 || BR_STAGE >= STAGES) begin : g_bad_br_stage
    $error("hazard_scoreboard: BR_STAGE must index a tracker slot (0..STAGES-1)");
  end

  // --------------------------------------------------------------------------
  // Tracker state
  // --------------------------------------------------------------------------
  sb_entry_t entry_q [STAGES];
  sb_entry_t entry_d [STAGES];

  logic [STAGES-1:0] src_hit;
  logic              window_hit;
  logic              load_use_hit;
  logic              hazard;

  // Per-slot source match of the decoding instruction. Only tracker entries
  // are compared, so an instruction never waits on its own destination.
  always_comb begin
    src_hit = '0;
    for (int i = 0; i < STAGES; i++) begin
      src_hit[i] = entry_q[i].v &
                   ((id_rs_valid & (id_rs == entry_q[i].rd)) |
                    (id_rt_valid & (id_rt == entry_q[i].rd)));
    end
  end

  // Reduce the matches to a single hazard according to the forwarding mode.
  always_comb begin
    window_hit = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if (i < WIN_LEN) begin
        window_hit = window_hit | src_hit[i];
      end
    end
    // With forwarding only a load still in EX cannot supply its result.
    load_use_hit = src_hit[0] & entry_q[0].ld;
    hazard       = (FWD_EN != 0) ? load_use_hit : window_hit;
  end

  // Control outputs; a taken branch squashes the decoding instruction, so
  // the flush wins over any stall it would otherwise have caused.
  always_comb begin
    stall       = id_valid & hazard & ~br_taken;
    flush_if_id = br_taken;
    flush_id_ex = br_taken;
  end

  // Tracker next state: shift one slot per cycle, insert the decoding
  // instruction at slot 0 only when it really advances into EX, and kill the
  // slots younger than the resolving branch as they move along.
  always_comb begin
    entry_d[0].v  = id_valid & id_rd_valid & ~stall & ~br_taken;
    entry_d[0].rd = id_rd;
    entry_d[0].ld = id_is_load;
    for (int i = 1; i < STAGES; i++) begin
      entry_d[i] = entry_q[i-1];
      if (br_taken && ((i - 1) < BR_STAGE)) begin
        entry_d[i].v = 1'b0;
      end
    end
  end

  // Tracker registers; reset empties every slot at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall),
    .count (stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (br_taken),
    .count (flush_cnt)
  );

endmodule : hazard_scoreboard
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Directed self-checking bench. Two scoreboards share one set
//                of decode inputs: one without forwarding and a 4-bit counter
//                width, one with load-use-only forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid, id_rs_valid, id_rt_valid, id_rd_valid, id_is_load, br_taken;
  logic [2:0] id_rs, id_rt, id_rd;

  logic        stall_nf, fif_nf, fie_nf;
  logic [3:0]  scnt_nf, fcnt_nf;
  logic        stall_fw, fif_fw, fie_fw;
  logic [15:0] scnt_fw, fcnt_fw;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NUM_REGS(8), .STAGES(3), .BR_STAGE(1), .FWD_EN(0), .WB_BYPASS(1), .CNT_W(4)
  ) dut_nf (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_valid(id_rs_valid), .id_rs(id_rs),
    .id_rt_valid(id_rt_valid), .id_rt(id_rt),
    .id_rd_valid(id_rd_valid), .id_rd(id_rd),
    .id_is_load(id_is_load), .br_taken(br_taken),
    .stall(stall_nf), .flush_if_id(fif_nf), .flush_id_ex(fie_nf),
    .stall_cnt(scnt_nf), .flush_cnt(fcnt_nf)
  );

  hazard_scoreboard #(
    .NUM_REGS(8), .STAGES(3), .BR_STAGE(1), .FWD_EN(1), .WB_BYPASS(1), .CNT_W(16)
  ) dut_fw (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_valid(id_rs_valid), .id_rs(id_rs),
    .id_rt_valid(id_rt_valid), .id_rt(id_rt),
    .id_rd_valid(id_rd_valid), .id_rd(id_rd),
    .id_is_load(id_is_load), .br_taken(br_taken),
    .stall(stall_fw), .flush_if_id(fif_fw), .flush_id_ex(fie_fw),
    .stall_cnt(scnt_fw), .flush_cnt(fcnt_fw)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rsv, input logic [2:0] rs,
                       input logic rtv, input logic [2:0] rt,
                       input logic rdv, input logic [2:0] rd,
                       input logic ld, input logic br);
    id_valid = v; id_rs_valid = rsv; id_rs = rs; id_rt_valid = rtv; id_rt = rt;
    id_rd_valid = rdv; id_rd = rd; id_is_load = ld; br_taken = br;
  endtask

  task automatic idle();
    drive(0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0);
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle; sampling lands mid-cycle.
  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    // ---------------- reset state ----------------
    next_cycle();
    next_cycle();
    settle();
    chk("rst_stall_nf", 32'(stall_nf), 0);
    chk("rst_flush_nf", 32'({fif_nf, fie_nf}), 0);
    chk("rst_scnt_nf",  32'(scnt_nf), 0);
    chk("rst_fcnt_nf",  32'(fcnt_nf), 0);
    chk("rst_stall_fw", 32'(stall_fw), 0);
    chk("rst_scnt_fw",  32'(scnt_fw), 0);
    rst = 1'b0;
    next_cycle();
    settle();
    chk("post_rst_stall", 32'(stall_nf), 0);

    // ---------------- RAW without forwarding: r3 writer then reader -------
    do_reset();
    drive(1, 0, 3'd0, 0, 3'd0, 1, 3'd3, 0, 0);
    settle();
    chk("raw_writer", 32'(stall_nf), 0);
    next_cycle();
    drive(1, 1, 3'd3, 0, 3'd0, 0, 3'd0, 0, 0);
    settle();
    chk("raw_c1", 32'(stall_nf), 1);
    next_cycle();
    settle();
    chk("raw_c2", 32'(stall_nf), 1);
    next_cycle();
    settle();
    chk("raw_c3_go", 32'(stall_nf), 0);
    chk("raw_scnt", 32'(scnt_nf), 2);
    next_cycle();
    idle();
    settle();
    chk("raw_scnt_hold", 32'(scnt_nf), 2);

    // ---------------- non-matches ----------------
    do_reset();
    drive(1, 0, 3'd0, 0, 3'd0, 1, 3'd4, 0, 0);
    next_cycle();
    drive(1, 0, 3'd4, 1, 3'd1, 0, 3'd0, 0, 0);
    settle();
    chk("rs_invalid", 32'(stall_nf), 0);
    next_cycle();
    drive(1, 1, 3'd4, 0, 3'd0, 0, 3'd0, 0, 0);
    settle();
    chk("rs_valid_ctrl", 32'(stall_nf), 1);
    next_cycle();
    drive(1, 0, 3'd0, 0, 3'd0, 0, 3'd6, 0, 0);
    next_cycle();
    drive(1, 1, 3'd6, 1, 3'd6, 0, 3'd0, 0, 0);
    settle();
    chk("rd_invalid_prod", 32'(stall_nf), 0);
    next_cycle();
    drive(1, 1, 3'd7, 0, 3'd0, 1, 3'd7, 0, 0);
    settle();
    chk("self_dep", 32'(stall_nf), 0);
    next_cycle();
    drive(1, 1, 3'd7, 0, 3'd0, 0, 3'd0, 0, 0);
    settle();
    chk("after_self", 32'(stall_nf), 1);
    next_cycle();
    idle();

    // ---------------- forwarding mode: load-use vs ALU producer -----------
    do_reset();
    drive(1, 0, 3'd0, 0, 3'd0, 1, 3'd5, 1, 0);
    settle();
    chk("fwd_load_issue", 32'(stall_fw), 0);
    next_cycle();
    drive(1, 1, 3'd5, 0, 3'd0, 0, 3'd0, 0, 0);
    settle();
    chk("fwd_load_use_c1", 32'(stall_fw), 1);
    next_cycle();
    settle();
    chk("fwd_load_use_c2", 32'(stall_fw), 0);
    chk("fwd_scnt", 32'(scnt_fw), 1);
    next_cycle();
    drive(1, 0, 3'd0, 0, 3'd0, 1, 3'd5, 0, 0);
    next_cycle();
    drive(1, 0, 3'd0, 1, 3'd5, 0, 3'd0, 0, 0);
    settle();
    chk("fwd_alu_c1", 32'(stall_fw), 0);
    next_cycle();
    settle();
    chk("fwd_alu_c2", 32'(stall_fw), 0);
    chk("fwd_scnt_hold", 32'(scnt_fw), 1);
    next_cycle();
    idle();

    // ---------------- branch flush ----------------
    do_reset();
    drive(1, 0, 3'd0, 0, 3'd0, 1, 3'd2, 0, 0);
    next_cycle();
    drive(1, 1, 3'd2, 0, 3'd0, 0, 3'd0, 0, 1);
    settle();
    chk("br_flush_if_id", 32'(fif_nf), 1);
    chk("br_flush_id_ex", 32'(fie_nf), 1);
    chk("br_stall_low",   32'(stall_nf), 0);
    chk("br_flush_fw",    32'({fif_fw, fie_fw}), 3);
    next_cycle();
    drive(1, 1, 3'd2, 0, 3'd0, 0, 3'd0, 0, 0);
    settle();
    chk("br_killed_entry", 32'(stall_nf), 0);
    chk("br_flush_off",    32'(fif_nf), 0);
    chk("br_fcnt",         32'(fcnt_nf), 1);
    chk("br_fcnt_fw",      32'(fcnt_fw), 1);
    chk("br_scnt",         32'(scnt_nf), 0);
    next_cycle();
    idle();
    next_cycle();
    next_cycle();

    // ---------------- asynchronous reset in the middle of a stall ---------
    drive(1, 0, 3'd0, 0, 3'd0, 1, 3'd3, 0, 0);
    next_cycle();
    drive(1, 1, 3'd3, 0, 3'd0, 0, 3'd0, 0, 0);
    settle();
    chk("mid_stall_c1", 32'(stall_nf), 1);
    next_cycle();
    settle();
    chk("mid_stall_c2",  32'(stall_nf), 1);
    chk("mid_scnt_pre",  32'(scnt_nf), 1);
    chk("mid_fcnt_pre",  32'(fcnt_nf), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", 32'(stall_nf), 0);
    chk("mid_rst_scnt",  32'(scnt_nf), 0);
    chk("mid_rst_fcnt",  32'(fcnt_nf), 0);
    rst = 1'b0;
    next_cycle();
    settle();
    chk("mid_rst_reader", 32'(stall_nf), 0);
    next_cycle();
    idle();

    // ---------------- counter saturation (4-bit) ----------------
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(1, 0, 3'd0, 0, 3'd0, 1, 3'd1, 0, 0);
      next_cycle();
      drive(1, 1, 3'd1, 0, 3'd0, 0, 3'd0, 0, 0);
      next_cycle();
      next_cycle();
      next_cycle();
      if (k == 6) begin
        settle();
        chk("sat_scnt_14", 32'(scnt_nf), 14);
      end
    end
    idle();
    settle();
    chk("sat_scnt_15", 32'(scnt_nf), 15);
    next_cycle();
    settle();
    chk("sat_idle_stall", 32'(stall_nf), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_hazard_scoreboard
`default_nettype wire
